// File: rtl/axis_stream_tester_if.sv
// AXI4-Stream bundle shared by the generator (master) and checker (slave) ports
// of axis_stream_tester.
interface axis_stream_tester_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_stream_tester.sv
// AXI4-Stream traffic generator and checker: emits NUM_PKTS packets of an
// incrementing pattern and checks a returned stream against the same pattern.
module axis_stream_tester #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    PKT_LEN    = 16,
    parameter int                    NUM_PKTS   = 4,
    parameter logic [DATA_WIDTH-1:0] SEED       = {DATA_WIDTH{1'b0}},
    parameter int                    IDLE_GAP   = 0
) (
    input  logic                 init_clk,
    input  logic                 s_axis_aresetn,
    input  logic                 start_write,
    input  logic                 start_read,
    axis_stream_tester_if.master m_axis,
    axis_stream_tester_if.slave  s_axis,
    output logic                 write_done,
    output logic                 read_done,
    output logic                 err,
    output logic [15:0]          err_cnt
);
    localparam int                    KW         = DATA_WIDTH / 8;
    localparam logic [31:0]           LAST_BEAT  = 32'(PKT_LEN * NUM_PKTS - 1);
    localparam logic [31:0]           LAST_POS   = 32'(PKT_LEN - 1);
    localparam logic [31:0]           GAP_LOAD   = (IDLE_GAP > 0) ? 32'(IDLE_GAP - 1) : 32'd0;
    localparam logic                  FIRST_LAST = (PKT_LEN == 1) ? 1'b1 : 1'b0;
    localparam logic [DATA_WIDTH-1:0] ONE        = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {G_IDLE = 2'd0, G_SEND = 2'd1, G_GAP = 2'd2, G_DONE = 2'd3} g_state_e;
    typedef enum logic [1:0] {C_IDLE = 2'd0, C_RECV = 2'd1, C_DONE = 2'd2} c_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] pos_inc(input logic [31:0] p);
        return (p == LAST_POS) ? 32'd0 : p + 32'd1;
    endfunction

    g_state_e              g_state_q, g_state_d;
    logic [31:0]           beat_q, beat_d;
    logic [31:0]           pos_q, pos_d;
    logic [31:0]           gap_q, gap_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;
    logic                  wdone_q, wdone_d;

    c_state_e              c_state_q, c_state_d;
    logic [31:0]           cbeat_q, cbeat_d;
    logic [31:0]           cpos_q, cpos_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  tready_q, tready_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  rdone_q, rdone_d;
    logic                  mismatch_s;
    logic                  unused_tkeep_s;

    // Generator next-state: the beat only advances on a handshake, so outputs hold while stalled.
    always_comb begin
        g_state_d = g_state_q;
        beat_d    = beat_q;
        pos_d     = pos_q;
        gap_d     = gap_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        wdone_d   = wdone_q;
        case (g_state_q)
            G_IDLE: begin
                if (start_write) begin
                    g_state_d = G_SEND;
                    beat_d    = 32'd0;
                    pos_d     = 32'd0;
                    tdata_d   = SEED;
                    tlast_d   = FIRST_LAST;
                    tvalid_d  = 1'b1;
                    wdone_d   = 1'b0;
                end else begin
                    tvalid_d  = 1'b0;
                end
            end
            G_SEND: begin
                if (m_axis.tready) begin
                    if (beat_q == LAST_BEAT) begin
                        g_state_d = G_DONE;
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        wdone_d   = 1'b1;
                    end else begin
                        beat_d  = beat_q + 32'd1;
                        tdata_d = tdata_q + ONE;
                        pos_d   = pos_inc(pos_q);
                        if ((pos_q == LAST_POS) && (IDLE_GAP > 0)) begin
                            g_state_d = G_GAP;
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_d     = GAP_LOAD;
                        end else begin
                            tlast_d = (pos_inc(pos_q) == LAST_POS);
                        end
                    end
                end else begin
                    tvalid_d = 1'b1;
                end
            end
            G_GAP: begin
                // A fresh packet always starts at position 0.
                if (gap_q == 32'd0) begin
                    g_state_d = G_SEND;
                    tvalid_d  = 1'b1;
                    tlast_d   = FIRST_LAST;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            G_DONE: begin
                if (!start_write) begin
                    g_state_d = G_IDLE;
                    wdone_d   = 1'b0;
                end else begin
                    wdone_d   = 1'b1;
                end
            end
            default: begin
                g_state_d = G_IDLE;
                tvalid_d  = 1'b0;
                tlast_d   = 1'b0;
                wdone_d   = 1'b0;
            end
        endcase
    end

    // Generator state and output registers.
    always_ff @(posedge init_clk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            g_state_q <= G_IDLE;
            beat_q    <= 32'd0;
            pos_q     <= 32'd0;
            gap_q     <= 32'd0;
            tdata_q   <= {DATA_WIDTH{1'b0}};
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            wdone_q   <= 1'b0;
        end else begin
            g_state_q <= g_state_d;
            beat_q    <= beat_d;
            pos_q     <= pos_d;
            gap_q     <= gap_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
            wdone_q   <= wdone_d;
        end
    end

    // Checker next-state: the expected counter follows handshakes only, never the received data.
    always_comb begin
        c_state_d  = c_state_q;
        cbeat_d    = cbeat_q;
        cpos_d     = cpos_q;
        exp_d      = exp_q;
        tready_d   = tready_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        rdone_d    = rdone_q;
        mismatch_s = 1'b0;
        case (c_state_q)
            C_IDLE: begin
                if (start_read) begin
                    c_state_d = C_RECV;
                    cbeat_d   = 32'd0;
                    cpos_d    = 32'd0;
                    exp_d     = SEED;
                    tready_d  = 1'b1;
                    err_d     = 1'b0;
                    cnt_d     = 16'd0;
                    rdone_d   = 1'b0;
                end else begin
                    tready_d  = 1'b0;
                end
            end
            C_RECV: begin
                if (s_axis.tvalid) begin
                    mismatch_s = (s_axis.tdata != exp_q) || (s_axis.tlast != (cpos_q == LAST_POS));
                    if (mismatch_s) begin
                        err_d = 1'b1;
                        cnt_d = sat_inc16(cnt_q);
                    end else begin
                        err_d = err_q;
                    end
                    exp_d   = exp_q + ONE;
                    cbeat_d = cbeat_q + 32'd1;
                    cpos_d  = pos_inc(cpos_q);
                    if (cbeat_q == LAST_BEAT) begin
                        c_state_d = C_DONE;
                        tready_d  = 1'b0;
                        rdone_d   = 1'b1;
                    end else begin
                        tready_d  = 1'b1;
                    end
                end else begin
                    tready_d = 1'b1;
                end
            end
            C_DONE: begin
                if (!start_read) begin
                    c_state_d = C_IDLE;
                    rdone_d   = 1'b0;
                end else begin
                    rdone_d   = 1'b1;
                end
            end
            default: begin
                c_state_d = C_IDLE;
                tready_d  = 1'b0;
                rdone_d   = 1'b0;
            end
        endcase
    end

    // Checker state and output registers.
    always_ff @(posedge init_clk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            c_state_q <= C_IDLE;
            cbeat_q   <= 32'd0;
            cpos_q    <= 32'd0;
            exp_q     <= {DATA_WIDTH{1'b0}};
            tready_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 16'd0;
            rdone_q   <= 1'b0;
        end else begin
            c_state_q <= c_state_d;
            cbeat_q   <= cbeat_d;
            cpos_q    <= cpos_d;
            exp_q     <= exp_d;
            tready_q  <= tready_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rdone_q   <= rdone_d;
        end
    end

    assign m_axis.tdata   = tdata_q;
    assign m_axis.tkeep   = {KW{tvalid_q}};
    assign m_axis.tlast   = tlast_q;
    assign m_axis.tvalid  = tvalid_q;
    assign s_axis.tready  = tready_q;
    assign write_done     = wdone_q;
    assign read_done      = rdone_q;
    assign err            = err_q;
    assign err_cnt        = cnt_q;
    assign unused_tkeep_s = ^s_axis.tkeep;
endmodule

// File: tb/tb_axis_stream_tester.sv
// Self-checking bench for axis_stream_tester: a FIFO loopback with random
// backpressure and corruption, plus gapped and narrow-width direct loopbacks.
module tb_axis_stream_tester;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n, a_start_w, a_start_r, bc_start;
    logic a_m_ready, a_s_valid, a_s_last;
    logic [31:0] a_s_data;
    logic a_wd, a_rd, a_err, b_wd, b_rd, b_err, c_wd, c_rd, c_err;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    axis_stream_tester_if #(.DATA_WIDTH(32)) a_m_if ();
    axis_stream_tester_if #(.DATA_WIDTH(32)) a_s_if ();
    axis_stream_tester_if #(.DATA_WIDTH(32)) b_m_if ();
    axis_stream_tester_if #(.DATA_WIDTH(32)) b_s_if ();
    axis_stream_tester_if #(.DATA_WIDTH(8))  c_m_if ();
    axis_stream_tester_if #(.DATA_WIDTH(8))  c_s_if ();

    assign a_m_if.tready = a_m_ready;
    assign a_s_if.tvalid = a_s_valid;
    assign a_s_if.tdata  = a_s_data;
    assign a_s_if.tlast  = a_s_last;
    assign a_s_if.tkeep  = 4'hF;

    assign b_m_if.tready = 1'b1;
    assign b_s_if.tvalid = b_m_if.tvalid;
    assign b_s_if.tdata  = b_m_if.tdata;
    assign b_s_if.tlast  = b_m_if.tlast;
    assign b_s_if.tkeep  = b_m_if.tkeep;

    assign c_m_if.tready = 1'b1;
    assign c_s_if.tvalid = c_m_if.tvalid;
    assign c_s_if.tdata  = c_m_if.tdata;
    assign c_s_if.tlast  = c_m_if.tlast;
    assign c_s_if.tkeep  = c_m_if.tkeep;

    axis_stream_tester u_a (
        .init_clk(clk), .s_axis_aresetn(rst_n), .start_write(a_start_w), .start_read(a_start_r),
        .m_axis(a_m_if), .s_axis(a_s_if),
        .write_done(a_wd), .read_done(a_rd), .err(a_err), .err_cnt(a_cnt));

    axis_stream_tester #(.IDLE_GAP(3)) u_b (
        .init_clk(clk), .s_axis_aresetn(rst_n), .start_write(bc_start), .start_read(bc_start),
        .m_axis(b_m_if), .s_axis(b_s_if),
        .write_done(b_wd), .read_done(b_rd), .err(b_err), .err_cnt(b_cnt));

    axis_stream_tester #(.DATA_WIDTH(8), .SEED(8'd250), .PKT_LEN(4), .NUM_PKTS(2)) u_c (
        .init_clk(clk), .s_axis_aresetn(rst_n), .start_write(bc_start), .start_read(bc_start),
        .m_axis(c_m_if), .s_axis(c_s_if),
        .write_done(c_wd), .read_done(c_rd), .err(c_err), .err_cnt(c_cnt));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitors for the direct loopbacks (tready is tied high, so every valid cycle is a beat).
    int b_cyc[$];
    logic [31:0] b_dat[$];
    logic b_lst[$];
    logic [7:0] c_dat[$];
    logic c_lst[$];
    always @(negedge clk) begin
        if (rst_n && b_m_if.tvalid) begin
            b_cyc.push_back(cyc);
            b_dat.push_back(b_m_if.tdata);
            b_lst.push_back(b_m_if.tlast);
        end
        if (rst_n && c_m_if.tvalid) begin
            c_dat.push_back(c_m_if.tdata);
            c_lst.push_back(c_m_if.tlast);
        end
    end

    task automatic check_a_zero(input string tag);
        chk({tag, "_tvalid"}, a_m_if.tvalid, 0);
        chk({tag, "_tdata"}, a_m_if.tdata, 0);
        chk({tag, "_tkeep"}, a_m_if.tkeep, 0);
        chk({tag, "_tlast"}, a_m_if.tlast, 0);
        chk({tag, "_tready"}, a_s_if.tready, 0);
        chk({tag, "_wdone"}, a_wd, 0);
        chk({tag, "_rdone"}, a_rd, 0);
        chk({tag, "_err"}, a_err, 0);
        chk({tag, "_errcnt"}, a_cnt, 0);
    endtask

    logic [31:0] fifo_d[$];
    logic        fifo_l[$];

    // One run on u_a through a bench FIFO; abort_at >= 0 leaves the run after that many sent beats.
    task automatic run_a(input bit rand_bp, input bit corrupt, input int abort_at);
        int sent = 0, recv = 0, budget = 0, first_hs = 0, last_hs = 0;
        bit stall_prev = 1'b0, wd_seen = 1'b0;
        logic [31:0] d_prev = 32'd0, d;
        logic l_prev = 1'b0, l;
        fifo_d.delete();
        fifo_l.delete();
        @(negedge clk);
        a_start_w = 1'b1;
        a_start_r = 1'b1;
        @(negedge clk);
        chk("a_first_tvalid", a_m_if.tvalid, 1);
        chk("a_first_tready", a_s_if.tready, 1);
        while (!(a_wd && a_rd) && budget < 2000) begin
            a_m_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            a_s_valid = (fifo_d.size() > 0) && (rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
            a_s_data  = (fifo_d.size() > 0) ? fifo_d[0] : 32'd0;
            a_s_last  = (fifo_l.size() > 0) ? fifo_l[0] : 1'b0;
            if (stall_prev) begin
                chk("a_stall_tvalid", a_m_if.tvalid, 1);
                chk("a_stall_tdata", a_m_if.tdata, d_prev);
                chk("a_stall_tlast", a_m_if.tlast, l_prev);
            end
            if (a_m_if.tvalid && a_m_ready) begin
                chk("a_tdata", a_m_if.tdata, 64'(sent));
                chk("a_tlast", a_m_if.tlast, (sent % 16) == 15);
                d = a_m_if.tdata;
                l = a_m_if.tlast;
                if (corrupt && sent == 5) d = 32'hFF;
                if (corrupt && sent == 15) l = 1'b0;
                fifo_d.push_back(d);
                fifo_l.push_back(l);
                if (sent == 0) first_hs = cyc;
                last_hs = cyc;
                sent++;
            end
            stall_prev = a_m_if.tvalid && !a_m_ready;
            d_prev     = a_m_if.tdata;
            l_prev     = a_m_if.tlast;
            if (a_s_valid && a_s_if.tready) begin
                void'(fifo_d.pop_front());
                void'(fifo_l.pop_front());
                recv++;
            end
            @(negedge clk);
            budget++;
            if (sent == 64 && !wd_seen) begin
                wd_seen = 1'b1;
                chk("a_wdone_latency", a_wd, 1);
            end
            if (abort_at >= 0 && sent == abort_at) break;
        end
        a_s_valid = 1'b0;
        if (abort_at < 0) begin
            chk("a_no_timeout", budget < 2000, 1);
            chk("a_beats_sent", sent, 64);
            chk("a_beats_recv", recv, 64);
            chk("a_err", a_err, corrupt ? 1 : 0);
            chk("a_err_cnt", a_cnt, corrupt ? 2 : 0);
            if (!rand_bp) chk("a_b2b_span", last_hs - first_hs, 63);
            a_start_w = 1'b0;
            a_start_r = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("a_wdone_drop", a_wd, 0);
            chk("a_rdone_drop", a_rd, 0);
            chk("a_err_sticky", a_err, corrupt ? 1 : 0);
        end
    endtask

    initial begin
        int nbad, ngap, span, waited;
        rst_n = 1'b0; a_start_w = 1'b0; a_start_r = 1'b0; bc_start = 1'b0;
        a_m_ready = 1'b0; a_s_valid = 1'b0; a_s_data = 32'd0; a_s_last = 1'b0;
        repeat (3) @(negedge clk);
        check_a_zero("rst");
        chk("rst_c_tdata", c_m_if.tdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back FIFO loopback on u_a while u_b (gapped) and u_c (8-bit) run direct.
        bc_start = 1'b1;
        run_a(1'b0, 1'b0, -1);
        waited = 0;
        while (!(b_wd && b_rd && c_wd && c_rd) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("bc_no_timeout", waited < 300, 1);

        chk("b_beats", b_dat.size(), 64);
        nbad = 0;
        ngap = 0;
        for (int k = 0; k < b_dat.size(); k++) begin
            if (b_dat[k] !== 32'(k) || b_lst[k] !== ((k % 16) == 15)) nbad++;
            if (k > 0 && (b_cyc[k] - b_cyc[k-1]) != (((k % 16) == 0) ? 4 : 1)) ngap++;
        end
        chk("b_pattern_bad", nbad, 0);
        chk("b_gap_bad", ngap, 0);
        span = (b_cyc.size() > 0) ? (b_cyc[b_cyc.size()-1] - b_cyc[0] + 1) : 0;
        chk("b_span", span, 73);
        chk("b_err", b_err, 0);
        chk("b_err_cnt", b_cnt, 0);

        chk("c_beats", c_dat.size(), 8);
        nbad = 0;
        for (int k = 0; k < c_dat.size(); k++) begin
            logic [7:0] e;
            e = 8'(250 + k);
            if (c_dat[k] !== e || c_lst[k] !== ((k % 4) == 3)) nbad++;
        end
        chk("c_pattern_bad", nbad, 0);
        chk("c_err", c_err, 0);
        chk("c_err_cnt", c_cnt, 0);
        bc_start = 1'b0;

        // Random backpressure on both sides of the FIFO.
        run_a(1'b1, 1'b0, -1);

        // Beat 5 data and beat 15 tlast corrupted in the loop.
        run_a(1'b0, 1'b1, -1);

        // Reset during beat 20, then a clean rerun.
        run_a(1'b1, 1'b0, 20);
        #1;
        rst_n = 1'b0;
        #1;
        check_a_zero("midrst");
        a_start_w = 1'b0;
        a_start_r = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_a_zero("postrst");
        run_a(1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
